rec_play_ctrl: RTL and testbench

REC_PLAY_CTRL -- requirements
Module: rec_play_ctrl

---
 rtl/rec_play_ctrl_if.sv | 26 ++
 rtl/rec_play_ctrl.sv | 117 +++++++++++
 tb/tb_rec_play_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rec_play_ctrl_if.sv
// Control and note-memory bus of the record/playback controller.
// master = user/keypad side, slave = rec_play_ctrl.
interface rec_play_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              rec_req;
   logic              play_req;
   logic              key_valid;
   logic              loop_en;
   logic              ce;
   logic              RW;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   len;
   logic [2:0]        state;
   logic              done;

   modport master (
      output rec_req, play_req, key_valid, loop_en,
      input  ce, RW, addr, len, state, done
   );

   modport slave (
      input  rec_req, play_req, key_valid, loop_en,
      output ce, RW, addr, len, state, done
   );
endinterface

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: stores key strobes into a note memory and
// replays them with a fixed gap, optionally looping.
module rec_play_ctrl #(
   parameter int ADDR_W   = 3,
   parameter int STEP_CYC = 4
) (
   input  logic           clock,
   input  logic           reset,
   rec_play_ctrl_if.slave bus
);
   localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [TW-1:0]     TIMER_LOAD = TW'(STEP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REC_WAIT = 3'd1,
      REC_WR   = 3'd2,
      PLAY_RD  = 3'd3,
      PLAY_GAP = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   last_idx;

   assign last_idx = len_q - LEN_ONE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         timer_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         timer_q <= timer_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      timer_d = timer_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rec_req) begin
               state_d = REC_WAIT;
               addr_d  = '0;
               len_d   = '0;
            end else if (bus.play_req && (len_q != '0)) begin
               state_d = PLAY_RD;
               addr_d  = '0;
            end
         end
         REC_WAIT: begin
            if (!bus.rec_req)
               state_d = IDLE;
            else if (bus.key_valid)
               state_d = REC_WR;
         end
         REC_WR: begin
            if (len_q < DEPTH_L)
               len_d = len_q + LEN_ONE;
            // A full memory ends recording here, so addr never wraps.
            if (addr_q == LAST_ADDR) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = REC_WAIT;
            end
         end
         PLAY_RD: begin
            timer_d = TIMER_LOAD;
            state_d = PLAY_GAP;
         end
         PLAY_GAP: begin
            // Abort outranks every timer decision and never pulses done.
            if (!bus.play_req)
               state_d = IDLE;
            else if (timer_q != '0)
               timer_d = timer_q - TW'(1);
            else if ({1'b0, addr_q} != last_idx) begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = PLAY_RD;
            end else if (bus.loop_en) begin
               addr_d  = '0;
               state_d = PLAY_RD;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ce    = (state_q == REC_WR) || (state_q == PLAY_RD);
   assign bus.RW    = (state_q == REC_WAIT) || (state_q == REC_WR);
   assign bus.addr  = addr_q;
   assign bus.len   = len_q;
   assign bus.state = state_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl: expected memory accesses are queued as
// stimulus is driven and checked by a monitor whenever ce is seen.
module tb_rec_play_ctrl;
   localparam int ADDR_W   = 3;
   localparam int STEP_CYC = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   rec_play_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   rec_play_ctrl #(.ADDR_W(ADDR_W), .STEP_CYC(STEP_CYC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      int                gap;   // cycles since previous access, 0 = unchecked
   } acc_t;

   acc_t exp_q[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   last_ce  = 0;
   int   done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic rw, input int a, input int gap);
      acc_t e;
      e.rw   = rw;
      e.addr = ADDR_W'(a);
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   // Assumes REC_WAIT: one strobe per key, each followed by the REC_WR cycle.
   task automatic rec_keys(input int n);
      for (int k = 0; k < n; k++) begin
         push(1'b1, k, 0);
         bus.key_valid = 1'b1;
         tick(1);
         bus.key_valid = 1'b0;
         tick(1);
      end
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (bus.state != 3'd0 && n < max) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(bus.state), 0);
   endtask

   always @(negedge clock) begin
      cyc++;
      if (reset && bus.done) done_cnt++;
      if (reset && bus.ce) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ce", 32'(bus.ce), 0);
         end else begin
            acc_t e;
            e = exp_q.pop_front();
            chk("acc_rw", 32'(bus.RW), 32'(e.rw));
            chk("acc_addr", 32'(bus.addr), 32'(e.addr));
            if (e.gap != 0) chk("acc_gap", cyc - last_ce, e.gap);
         end
         last_ce = cyc;
      end
   end

   initial begin
      bus.rec_req   = 1'b0;
      bus.play_req  = 1'b0;
      bus.key_valid = 1'b0;
      bus.loop_en   = 1'b0;

      // Reset state
      tick(1);
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_addr",  32'(bus.addr), 0);
      chk("rst_len",   32'(bus.len), 0);
      chk("rst_done",  32'(bus.done), 0);
      chk("rst_ce",    32'(bus.ce), 0);
      chk("rst_rw",    32'(bus.RW), 0);
      reset = 1'b1;
      tick(1);
      chk("idle_after_rst", 32'(bus.state), 0);

      // Record three keys, then release rec_req
      done_cnt = 0;
      bus.rec_req = 1'b1;
      tick(1);
      chk("rec_wait_state", 32'(bus.state), 1);
      chk("rec_wait_rw", 32'(bus.RW), 1);
      rec_keys(3);
      bus.rec_req = 1'b0;
      tick(1);
      chk("rec3_state", 32'(bus.state), 0);
      chk("rec3_len", 32'(bus.len), 3);
      chk("rec3_done", 32'(done_cnt), 0);
      chk("rec3_q", exp_q.size(), 0);

      // Play three notes without looping
      done_cnt = 0;
      push(1'b0, 0, 0);
      push(1'b0, 1, STEP_CYC + 1);
      push(1'b0, 2, STEP_CYC + 1);
      bus.play_req = 1'b1;
      tick(1);
      chk("play_start", 32'(bus.state), 3);
      wait_idle("play3_end", 40);
      bus.play_req = 1'b0;
      chk("play3_done_hi", 32'(bus.done), 1);
      tick(1);
      chk("play3_done_lo", 32'(bus.done), 0);
      chk("play3_done_cnt", 32'(done_cnt), 1);
      chk("play3_q", exp_q.size(), 0);

      // Fill all eight slots; a ninth key must be ignored
      done_cnt = 0;
      bus.rec_req = 1'b1;
      tick(1);
      chk("fill_len_clr", 32'(bus.len), 0);
      rec_keys(7);
      push(1'b1, 7, 0);
      bus.key_valid = 1'b1;
      tick(1);
      bus.key_valid = 1'b0;
      tick(1);
      chk("fill_state", 32'(bus.state), 0);
      chk("fill_done_hi", 32'(bus.done), 1);
      chk("fill_len", 32'(bus.len), 8);
      bus.rec_req   = 1'b0;
      bus.key_valid = 1'b1;
      tick(1);
      bus.key_valid = 1'b0;
      chk("key9_state", 32'(bus.state), 0);
      chk("key9_ce", 32'(bus.ce), 0);
      chk("key9_len", 32'(bus.len), 8);
      tick(2);
      chk("fill_done_cnt", 32'(done_cnt), 1);
      chk("fill_q", exp_q.size(), 0);

      // Two notes looping, aborted inside the gap
      bus.rec_req = 1'b1;
      tick(1);
      rec_keys(2);
      bus.rec_req = 1'b0;
      tick(1);
      chk("loop_len", 32'(bus.len), 2);
      done_cnt = 0;
      bus.loop_en = 1'b1;
      push(1'b0, 0, 0);
      for (int i = 1; i < 5; i++) push(1'b0, i % 2, STEP_CYC + 1);
      bus.play_req = 1'b1;
      tick(4 * (STEP_CYC + 1) + 2);
      chk("loop_in_gap", 32'(bus.state), 4);
      bus.play_req = 1'b0;
      tick(1);
      chk("abort_state", 32'(bus.state), 0);
      chk("abort_done", 32'(bus.done), 0);
      tick(3);
      chk("abort_done_cnt", 32'(done_cnt), 0);
      chk("abort_len", 32'(bus.len), 2);
      chk("loop_q", exp_q.size(), 0);
      bus.loop_en = 1'b0;

      // rec_req beats play_req in IDLE
      bus.rec_req  = 1'b1;
      bus.play_req = 1'b1;
      tick(1);
      chk("prio_state", 32'(bus.state), 1);
      chk("prio_len", 32'(bus.len), 0);
      bus.play_req = 1'b0;
      rec_keys(2);
      bus.rec_req = 1'b0;
      tick(1);
      chk("rerec_len", 32'(bus.len), 2);

      // Asynchronous reset during a playback gap
      push(1'b0, 0, 0);
      push(1'b0, 1, STEP_CYC + 1);
      bus.play_req = 1'b1;
      tick(STEP_CYC + 4);
      chk("pre_rst_gap", 32'(bus.state), 4);
      #2 reset = 1'b0;
      #1;
      chk("arst_state", 32'(bus.state), 0);
      chk("arst_addr",  32'(bus.addr), 0);
      chk("arst_len",   32'(bus.len), 0);
      chk("arst_done",  32'(bus.done), 0);
      chk("arst_ce",    32'(bus.ce), 0);
      chk("arst_rw",    32'(bus.RW), 0);
      tick(1);
      reset = 1'b1;
      tick(2);
      chk("post_rst_state", 32'(bus.state), 0);
      chk("post_rst_ce", 32'(bus.ce), 0);
      bus.play_req = 1'b0;
      tick(1);
      chk("final_q", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
